traffic_phase_timer: RTL and testbench
======================================

Name: traffic_phase_timer

Overview:
Timing companion to the traffic FSM. Watches the FSM's current state, loads that phase's duration, and counts it down in seconds from the system clock. On expiry it emits the single-cycle `triggerNextEvent` pulse that advances the FSM. It also preempts the running phase when an emergency request arrives, and exports a seconds-remaining value for the display.

Parameters:
- TICKS_PER_SEC, 50_000_000, clk cycles per second (prescaler modulus, >=2)
- SEC_W, 6, width of seconds counter and `secondsRemaining`
- T_S0, 55, seconds in S0 (all-red, walk)
- T_S1, 5, seconds in S1
- T_S2, 30, seconds in S2
- T_S3, 5, seconds in S3
- T_S4, 30, seconds in S4
- T_EMG, 10, seconds in S5/S6 (emergency)
- T_DEFAULT, 1, seconds for illegal state codes 7..15
- ACK_TIMEOUT, 4, cycles to wait for a state change after a trigger

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- currentState  in  4  FSM state code S0..S6
- emergency_left  in  1  raw async emergency request
- emergency_right  in  1  raw async emergency request
- triggerNextEvent  out  1  registered one-clk pulse advancing the FSM
- secondsRemaining  out  SEC_W  seconds left in current phase
- timerState  out  2  internal state, for debug

Behaviour:
- Reset (async, active-high):
  - `triggerNextEvent`=0, `secondsRemaining`=0, prescaler=0, `timerState`=LOAD.
  - Emergency synchroniser flops clear to 0.
- States (2-bit): LOAD=0, COUNT=1, FIRE=2, WAIT_ACK=3.
- LOAD (1 cycle):
  - Latch `currentState` into `latchedState`.
  - `secondsRemaining` = duration(`currentState`); a duration of 0 is forced to 1.
  - Prescaler=0, then go to COUNT.
- COUNT:
  - Prescaler increments each clk and wraps at TICKS_PER_SEC-1.
  - On wrap with `secondsRemaining`>1: decrement `secondsRemaining`.
  - On wrap with `secondsRemaining`==1: set `secondsRemaining`=0 and go to FIRE.
  - Net effect: the pulse is high exactly 1 + D*TICKS_PER_SEC cycles after LOAD is entered.
- FIRE (1 cycle): `triggerNextEvent`=1 (registered, so it is high for exactly this one clk), then go to WAIT_ACK.
- WAIT_ACK:
  - `triggerNextEvent`=0; a counter runs 0..ACK_TIMEOUT-1.
  - Exit to LOAD when `currentState` != `latchedState`, or when the counter expires. Expiry covers a legal self-transition such as S5->S5 while emergency is still held.
- External state change: if `currentState` != `latchedState` while in COUNT, abandon the count and go to LOAD next cycle. No trigger is issued.
- Priority within COUNT (highest first): state change, emergency preempt, expiry.
- Emergency inputs:
  - Each passes through a 2-flop synchroniser.
  - The synchronised OR is used only by the optional preempt feature.
- Illegal states 7..15: load T_DEFAULT and fire normally, so the FSM is always kicked.
- Duration parameters wider than SEC_W: elaboration error via a static check.

Optional Feature:
- Macro: EMERGENCY_PREEMPT_EN.
- When defined:
  - In COUNT, if the synchronised emergency is high and `latchedState` is not S5/S6, go to FIRE next cycle.
  - `secondsRemaining` is forced to 0.
  - Worst-case latency from the raw request rising to the trigger pulse is 4 clk: 2 sync + 1 decision + FIRE.
- When undefined:
  - Emergency inputs are ignored (synchroniser omitted).
  - The FSM samples emergency only at natural phase expiry.

Decomposition:
- Shared package `traffic_pkg`:
  - State codes S0..S6 (4-bit localparams).
  - Timer state encoding LOAD/COUNT/FIRE/WAIT_ACK.
  - Function `phase_duration(state)` returning seconds, default T_DEFAULT.
  - The package is also used by the FSM.
- One natural sub-module, `sec_prescaler`: free-running modulo-TICKS_PER_SEC counter with synchronous clear and a `tick` output asserted on wrap.

Test Plan (TICKS_PER_SEC=4):
- Reset, then `currentState`=S1 (5s) -> `triggerNextEvent` pulses once, exactly 1+20 cycles after LOAD. `secondsRemaining` steps 5,4,3,2,1,0, changing every 4 cycles.
- Bench FSM closes the loop from S0 -> sequence S0..S4..S0. Pulse spacings are (1+D*4)+WAIT_ACK exit for D=55,5,30,5,30. Each pulse is high exactly 1 cycle.
- Hold `currentState`=S5 after the trigger (no change) -> WAIT_ACK times out after 4 cycles, reloads 10s, and fires again 41 cycles later.
- Change `currentState` S2->S4 mid-count at `secondsRemaining`=17 -> no pulse. LOAD next cycle, then `secondsRemaining`=30.
- With EMERGENCY_PREEMPT_EN, in S2 at `secondsRemaining`=20, raise `emergency_left` -> trigger within 4 cycles. The same request while `latchedState`=S6 -> no preempt.
- Assert `reset` mid-COUNT asynchronously -> outputs 0 immediately, without waiting for a clk edge. Release -> LOAD, with the count restarting from full duration.

Source files
------------

// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared state codes, timer encoding and phase duration lookup
package traffic_pkg;

  localparam logic [3:0] S0 = 4'd0;
  localparam logic [3:0] S1 = 4'd1;
  localparam logic [3:0] S2 = 4'd2;
  localparam logic [3:0] S3 = 4'd3;
  localparam logic [3:0] S4 = 4'd4;
  localparam logic [3:0] S5 = 4'd5;
  localparam logic [3:0] S6 = 4'd6;

  typedef enum logic [1:0] {
    LOAD     = 2'd0,
    COUNT    = 2'd1,
    FIRE     = 2'd2,
    WAIT_ACK = 2'd3
  } timer_state_e;

  // Illegal codes fall through to t_def so the FSM is always kicked eventually.
  function automatic int unsigned phase_duration(
    input logic [3:0]  st,
    input int unsigned t_s0,
    input int unsigned t_s1,
    input int unsigned t_s2,
    input int unsigned t_s3,
    input int unsigned t_s4,
    input int unsigned t_emg,
    input int unsigned t_def
  );
    case (st)
      S0:      return t_s0;
      S1:      return t_s1;
      S2:      return t_s2;
      S3:      return t_s3;
      S4:      return t_s4;
      S5, S6:  return t_emg;
      default: return t_def;
    endcase
  endfunction

endpackage

// File: rtl/sec_prescaler.sv
// rtl/sec_prescaler.sv - modulo-TICKS clock-cycle counter, tick on wrap, sync clear
module sec_prescaler #(
  parameter int unsigned TICKS = 4
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clear_i,
  output logic tick_o
);

  localparam int unsigned W = $clog2(TICKS);
  localparam logic [W-1:0] LAST = W'(TICKS - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + W'(1);
    if (clear_i || cnt_q == LAST) cnt_d = '0;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign tick_o = !clear_i && (cnt_q == LAST);

endmodule

// File: rtl/traffic_phase_timer.sv
// rtl/traffic_phase_timer.sv - phase countdown and trigger pulse; EMERGENCY_PREEMPT_EN enables emergency preempt
module traffic_phase_timer
  import traffic_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = 50_000_000,
  parameter int unsigned SEC_W         = 6,
  parameter int unsigned T_S0          = 55,
  parameter int unsigned T_S1          = 5,
  parameter int unsigned T_S2          = 30,
  parameter int unsigned T_S3          = 5,
  parameter int unsigned T_S4          = 30,
  parameter int unsigned T_EMG         = 10,
  parameter int unsigned T_DEFAULT     = 1,
  parameter int unsigned ACK_TIMEOUT   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       currentState,
  input  logic             emergency_left,
  input  logic             emergency_right,
  output logic             triggerNextEvent,
  output logic [SEC_W-1:0] secondsRemaining,
  output logic [1:0]       timerState
);

  localparam longint unsigned SEC_MAX = (64'd1 << SEC_W) - 64'd1;
  localparam int unsigned AW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [AW-1:0] ACK_LAST = AW'(ACK_TIMEOUT - 1);

  if (64'(T_S0) > SEC_MAX || 64'(T_S1) > SEC_MAX || 64'(T_S2) > SEC_MAX ||
      64'(T_S3) > SEC_MAX || 64'(T_S4) > SEC_MAX || 64'(T_EMG) > SEC_MAX ||
      64'(T_DEFAULT) > SEC_MAX) begin : g_dur_too_wide
    $error("traffic_phase_timer: a phase duration does not fit in SEC_W bits");
  end
  if (TICKS_PER_SEC < 2) begin : g_ticks_too_small
    $error("traffic_phase_timer: TICKS_PER_SEC must be at least 2");
  end

  timer_state_e     state_q, state_d;
  logic [SEC_W-1:0] secs_q, secs_d;
  logic [3:0]       latched_q, latched_d;
  logic [AW-1:0]    ack_q, ack_d;
  logic             trig_q, trig_d;
  logic             tick;
  logic             preempt;
  logic [SEC_W-1:0] raw_dur, load_dur;

`ifdef EMERGENCY_PREEMPT_EN
  logic [1:0] emg_l_q, emg_r_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      emg_l_q <= '0;
      emg_r_q <= '0;
    end else begin
      emg_l_q <= {emg_l_q[0], emergency_left};
      emg_r_q <= {emg_r_q[0], emergency_right};
    end
  end

  // Emergency phases are never preempted by another emergency.
  assign preempt = (emg_l_q[1] | emg_r_q[1]) && (latched_q != S5) && (latched_q != S6);
`else
  logic unused_emergency;
  assign unused_emergency = emergency_left | emergency_right;
  assign preempt = 1'b0;
`endif

  sec_prescaler #(.TICKS(TICKS_PER_SEC)) u_prescaler (
    .clk_i   (clk),
    .reset_i (reset),
    .clear_i (state_q != COUNT),
    .tick_o  (tick)
  );

  assign raw_dur  = SEC_W'(phase_duration(currentState, T_S0, T_S1, T_S2, T_S3, T_S4,
                                          T_EMG, T_DEFAULT));
  assign load_dur = (raw_dur == '0) ? SEC_W'(1) : raw_dur;

  always_comb begin
    state_d   = state_q;
    secs_d    = secs_q;
    latched_d = latched_q;
    ack_d     = '0;
    case (state_q)
      LOAD: begin
        latched_d = currentState;
        secs_d    = load_dur;
        state_d   = COUNT;
      end
      COUNT: begin
        if (currentState != latched_q) begin
          state_d = LOAD;
        end else if (preempt) begin
          secs_d  = '0;
          state_d = FIRE;
        end else if (tick) begin
          if (secs_q > SEC_W'(1)) begin
            secs_d = secs_q - SEC_W'(1);
          end else begin
            secs_d  = '0;
            state_d = FIRE;
          end
        end
      end
      FIRE: state_d = WAIT_ACK;
      WAIT_ACK: begin
        // Timeout covers a legal self-transition that never changes currentState.
        if (currentState != latched_q || ack_q == ACK_LAST) state_d = LOAD;
        else                                                 ack_d   = ack_q + AW'(1);
      end
      default: state_d = LOAD;
    endcase
    trig_d = (state_d == FIRE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= LOAD;
      secs_q    <= '0;
      latched_q <= '0;
      ack_q     <= '0;
      trig_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      secs_q    <= secs_d;
      latched_q <= latched_d;
      ack_q     <= ack_d;
      trig_q    <= trig_d;
    end
  end

  assign triggerNextEvent = trig_q;
  assign secondsRemaining = secs_q;
  assign timerState       = state_q;

endmodule

// File: tb/tb_traffic_phase_timer.sv
// tb/tb_traffic_phase_timer.sv - directed self-checking bench for traffic_phase_timer
module tb_traffic_phase_timer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] cur = 4'd0;
  logic       el = 1'b0;
  logic       er = 1'b0;
  logic       trig;
  logic [5:0] secs;
  logic [1:0] tst;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  traffic_phase_timer #(.TICKS_PER_SEC(4)) dut (
    .clk              (clk),
    .reset            (reset),
    .currentState     (cur),
    .emergency_left   (el),
    .emergency_right  (er),
    .triggerNextEvent (trig),
    .secondsRemaining (secs),
    .timerState       (tst)
  );

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input logic [3:0] st);
    @(negedge clk);
    reset = 1'b1;
    cur   = st;
    el    = 1'b0;
    er    = 1'b0;
    step(2);
    reset = 1'b0;
  endtask

  task automatic wait_pulse(input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget && n < 0; i++) begin
      @(negedge clk);
      if (trig === 1'b1) n = i;
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++; if (trig !== 1'b0) begin errors++; $display("FAIL reset_trig got=%0b exp=0", trig); end
    checks++; if (secs !== 6'd0) begin errors++; $display("FAIL reset_secs got=%0d exp=0", secs); end
    checks++; if (tst !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", tst); end
  endtask

  task automatic test_single_s1;
    int exp;
    do_reset(4'd1);
    for (int k = 1; k <= 20; k++) begin
      step(1);
      exp = 5 - (k - 1) / 4;
      checks++; if (secs !== 6'(exp)) begin errors++; $display("FAIL s1_secs k=%0d got=%0d exp=%0d", k, secs, exp); end
      checks++; if (trig !== 1'b0) begin errors++; $display("FAIL s1_early_pulse k=%0d got=%0b exp=0", k, trig); end
    end
    step(1);
    checks++; if (trig !== 1'b1) begin errors++; $display("FAIL s1_pulse got=%0b exp=1", trig); end
    checks++; if (secs !== 6'd0) begin errors++; $display("FAIL s1_secs_at_fire got=%0d exp=0", secs); end
    step(1);
    checks++; if (trig !== 1'b0) begin errors++; $display("FAIL s1_pulse_width got=%0b exp=0", trig); end
    checks++; if (tst !== 2'd3) begin errors++; $display("FAIL s1_wait_ack got=%0d exp=3", tst); end
  endtask

  task automatic test_closed_loop;
    logic [3:0] nxt [5] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
    int         gap [5] = '{23, 123, 23, 123, 223};
    int n;
    do_reset(4'd0);
    wait_pulse(300, n);
    checks++; if (n != 221) begin errors++; $display("FAIL loop_first got=%0d exp=221", n); end
    for (int i = 0; i < 5; i++) begin
      cur = nxt[i];
      wait_pulse(300, n);
      checks++; if (n != gap[i]) begin errors++; $display("FAIL loop_gap[%0d] got=%0d exp=%0d", i, n, gap[i]); end
    end
    step(1);
    checks++; if (trig !== 1'b0) begin errors++; $display("FAIL loop_width got=%0b exp=0", trig); end
  endtask

  task automatic test_hold_s5;
    int n;
    do_reset(4'd5);
    wait_pulse(60, n);
    checks++; if (n != 41) begin errors++; $display("FAIL hold_first got=%0d exp=41", n); end
    for (int k = 1; k <= 4; k++) begin
      step(1);
      checks++; if (tst !== 2'd3) begin errors++; $display("FAIL hold_wait k=%0d got=%0d exp=3", k, tst); end
    end
    step(1);
    checks++; if (tst !== 2'd0) begin errors++; $display("FAIL hold_reload got=%0d exp=0", tst); end
    wait_pulse(60, n);
    checks++; if (n != 41) begin errors++; $display("FAIL hold_refire got=%0d exp=41", n); end
  endtask

  task automatic test_state_change;
    int n;
    do_reset(4'd2);
    step(53);
    checks++; if (secs !== 6'd17) begin errors++; $display("FAIL chg_secs17 got=%0d exp=17", secs); end
    cur = 4'd4;
    step(1);
    checks++; if (tst !== 2'd0) begin errors++; $display("FAIL chg_load got=%0d exp=0", tst); end
    checks++; if (trig !== 1'b0) begin errors++; $display("FAIL chg_no_pulse got=%0b exp=0", trig); end
    step(1);
    checks++; if (secs !== 6'd30) begin errors++; $display("FAIL chg_reload got=%0d exp=30", secs); end
    checks++; if (tst !== 2'd1) begin errors++; $display("FAIL chg_count got=%0d exp=1", tst); end
    wait_pulse(200, n);
    checks++; if (n != 120) begin errors++; $display("FAIL chg_fire got=%0d exp=120", n); end
  endtask

  task automatic test_emergency;
    int n;
    do_reset(4'd2);
    step(41);
    checks++; if (secs !== 6'd20) begin errors++; $display("FAIL emg_secs20 got=%0d exp=20", secs); end
    el = 1'b1;
`ifdef EMERGENCY_PREEMPT_EN
    wait_pulse(4, n);
    checks++; if (n != 3) begin errors++; $display("FAIL emg_preempt got=%0d exp=3", n); end
    checks++; if (secs !== 6'd0) begin errors++; $display("FAIL emg_secs0 got=%0d exp=0", secs); end
`else
    wait_pulse(200, n);
    checks++; if (n != 80) begin errors++; $display("FAIL emg_ignored got=%0d exp=80", n); end
`endif
    el = 1'b0;
    do_reset(4'd6);
    step(5);
    er = 1'b1;
    wait_pulse(60, n);
    checks++; if (n != 36) begin errors++; $display("FAIL emg_s6_no_preempt got=%0d exp=36", n); end
    er = 1'b0;
  endtask

  task automatic test_async_reset;
    do_reset(4'd2);
    step(10);
    checks++; if (secs !== 6'd28) begin errors++; $display("FAIL ares_pre got=%0d exp=28", secs); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (secs !== 6'd0) begin errors++; $display("FAIL ares_secs got=%0d exp=0", secs); end
    checks++; if (tst !== 2'd0) begin errors++; $display("FAIL ares_state got=%0d exp=0", tst); end
    checks++; if (trig !== 1'b0) begin errors++; $display("FAIL ares_trig got=%0b exp=0", trig); end
    @(negedge clk);
    reset = 1'b0;
    step(1);
    checks++; if (secs !== 6'd30) begin errors++; $display("FAIL ares_restart got=%0d exp=30", secs); end
    checks++; if (tst !== 2'd1) begin errors++; $display("FAIL ares_count got=%0d exp=1", tst); end
  endtask

  initial begin
    test_reset();
    test_single_s1();
    test_closed_loop();
    test_hold_s5();
    test_state_change();
    test_emergency();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
